// File: rtl/gf180_sram_pkg.sv
// Shared definitions for the GF180 1RW1R SRAM behavioural model: sequencer
// state encoding, default geometry and the write-lane merge helper.
package gf180_sram_pkg;

  localparam int unsigned DEF_DATA_WIDTH  = 8;
  localparam int unsigned DEF_ADDR_WIDTH  = 10;
  localparam int unsigned DEF_WMASK_WIDTH = 1;

  // Upper bounds for the lane_merge helper; wider configurations are rejected at elaboration.
  localparam int unsigned MAX_DATA_WIDTH  = 256;
  localparam int unsigned MAX_LANES       = 32;

  typedef logic [0:0] sram_state_t;
  localparam sram_state_t ST_CLEAR = 1'b0;
  localparam sram_state_t ST_RUN   = 1'b1;

  // Expand a per-lane mask to bit granularity and merge new data into the old word.
  function automatic logic [MAX_DATA_WIDTH-1:0] lane_merge(
    input logic [MAX_DATA_WIDTH-1:0] old_word,
    input logic [MAX_DATA_WIDTH-1:0] new_word,
    input logic [MAX_LANES-1:0]      mask,
    input int unsigned               lane_w
  );
    logic [MAX_DATA_WIDTH-1:0] lane_ones;
    logic [MAX_DATA_WIDTH-1:0] bit_mask;
    lane_ones = (MAX_DATA_WIDTH'(1) << lane_w) - MAX_DATA_WIDTH'(1);
    bit_mask  = '0;
    for (int unsigned j = 0; j < MAX_LANES; j++) begin
      if (mask[j]) bit_mask = bit_mask | (lane_ones << (j * lane_w));
    end
    return (old_word & ~bit_mask) | (new_word & bit_mask);
  endfunction

endpackage

// File: rtl/gf180_sram_clear_seq.sv
// Post-reset clear sequencer: walks clr_addr over the whole array while in
// CLEAR and raises ready once the last word has been zeroed.
module gf180_sram_clear_seq
  import gf180_sram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int unsigned RAM_DEPTH      = 32'(1) << ADDR_WIDTH,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk0,
  input  logic                  rst0,
  output sram_state_t           state,
  output logic [ADDR_WIDTH-1:0] clr_addr,
  output logic                  ready
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

  // Sequencer state, clear pointer and ready flag; reset restarts from address 0.
  always_ff @(posedge clk0) begin
    if (rst0) begin
      state    <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      clr_addr <= '0;
      ready    <= 1'b0;
    end else if (state == ST_CLEAR) begin
      if (clr_addr == LAST_ADDR) begin
        state <= ST_RUN;
        ready <= 1'b1;
      end else begin
        clr_addr <= clr_addr + 1'b1;
      end
    end else begin
      ready <= 1'b1;
    end
  end

endmodule

// File: rtl/gf180_sram_1rw1r_wmask.sv
// Behavioural GF180 OpenRAM-style macro: port 0 read/write with lane mask,
// port 1 read-only. Inputs are registered at posedge, the array is accessed
// at negedge. A synchronous reset zero-fills the array via the clear sequencer.
module gf180_sram_1rw1r_wmask
  import gf180_sram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int unsigned RAM_DEPTH      = 32'(1) << ADDR_WIDTH,
  parameter int unsigned WMASK_WIDTH    = DEF_WMASK_WIDTH,
  parameter bit          CLEAR_ON_RESET = 1'b1,
  parameter bit          VERBOSE        = 1'b1
) (
  input  logic                   clk0,
  input  logic                   rst0,
  input  logic                   csb0,
  input  logic                   web0,
  input  logic [WMASK_WIDTH-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0]  addr0,
  input  logic [DATA_WIDTH-1:0]  din0,
  output logic [DATA_WIDTH-1:0]  dout0,
  input  logic                   csb1,
  input  logic [ADDR_WIDTH-1:0]  addr1,
  output logic [DATA_WIDTH-1:0]  dout1,
  output logic                   ready
);

  localparam int unsigned LW = DATA_WIDTH / WMASK_WIDTH;

  if (DATA_WIDTH % WMASK_WIDTH != 0) begin : g_bad_mask
    $error("DATA_WIDTH (%0d) must be a multiple of WMASK_WIDTH (%0d)", DATA_WIDTH, WMASK_WIDTH);
  end
  if (DATA_WIDTH > MAX_DATA_WIDTH || WMASK_WIDTH > MAX_LANES) begin : g_too_wide
    $error("DATA_WIDTH/WMASK_WIDTH exceed lane_merge limits");
  end

  sram_state_t            state;
  logic [ADDR_WIDTH-1:0]  clr_addr;

  logic                   csb0_reg;
  logic                   web0_reg;
  logic [WMASK_WIDTH-1:0] wmask0_reg;
  logic [ADDR_WIDTH-1:0]  addr0_reg;
  logic [DATA_WIDTH-1:0]  din0_reg;
  logic                   csb1_reg;
  logic [ADDR_WIDTH-1:0]  addr1_reg;
  // Remembers a reset posedge so dout reads as zero before the next negedge.
  logic                   rst0_reg;

  logic [DATA_WIDTH-1:0]  mem [RAM_DEPTH];
  logic [DATA_WIDTH-1:0]  dout0_q;
  logic [DATA_WIDTH-1:0]  dout1_q;
  logic [MAX_DATA_WIDTH-1:0] merged;

  logic port0_wr;
  logic port0_rd;
  logic port1_rd;

  gf180_sram_clear_seq #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .RAM_DEPTH      (RAM_DEPTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_seq (
    .clk0     (clk0),
    .rst0     (rst0),
    .state    (state),
    .clr_addr (clr_addr),
    .ready    (ready)
  );

  // Input capture; chip selects are forced off during reset and while not ready.
  always_ff @(posedge clk0) begin
    csb0_reg   <= rst0 | ~ready | csb0;
    csb1_reg   <= rst0 | ~ready | csb1;
    web0_reg   <= rst0 | web0;
    wmask0_reg <= wmask0;
    addr0_reg  <= addr0;
    din0_reg   <= din0;
    addr1_reg  <= addr1;
    rst0_reg   <= rst0;
  end

  assign port0_wr = !csb0_reg && !web0_reg;
  assign port0_rd = !csb0_reg &&  web0_reg;
  assign port1_rd = !csb1_reg;

  // Lane-masked merge of the port 0 write data into the addressed word.
  always_comb begin
    merged = lane_merge(MAX_DATA_WIDTH'(mem[addr0_reg]), MAX_DATA_WIDTH'(din0_reg),
                        MAX_LANES'(wmask0_reg), LW);
  end

  // Array update: clear sequencer owns the array until it reaches RUN.
  always_ff @(negedge clk0) begin
    if (state == ST_CLEAR) begin
      mem[clr_addr] <= '0;
    end else if (port0_wr) begin
      mem[addr0_reg] <= merged[DATA_WIDTH-1:0];
    end
  end

  // Port 0 read data; holds while deselected or writing.
  always_ff @(negedge clk0) begin
    if (rst0_reg) begin
      dout0_q <= '0;
    end else if (port0_rd) begin
      dout0_q <= mem[addr0_reg];
    end
  end

  // Port 1 read data; same-cycle port 0 write is not forwarded.
  always_ff @(negedge clk0) begin
    if (rst0_reg) begin
      dout1_q <= '0;
    end else if (port1_rd) begin
      dout1_q <= mem[addr1_reg];
    end
  end

  assign dout0 = rst0_reg ? '0 : dout0_q;
  assign dout1 = rst0_reg ? '0 : dout1_q;

  // Access trace and collision reporting (simulation only).
  always @(negedge clk0) begin
    if (state == ST_RUN && port0_wr && port1_rd && addr0_reg == addr1_reg) begin
      $warning("collision: port0 write and port1 read at addr 0x%0h", addr0_reg);
    end
    if (VERBOSE) begin
      if (port0_wr) $info("port0 write addr 0x%0h data 0x%0h mask 0x%0h",
                          addr0_reg, din0_reg, wmask0_reg);
      if (port0_rd) $info("port0 read addr 0x%0h data 0x%0h", addr0_reg, mem[addr0_reg]);
      if (port1_rd) $info("port1 read addr 0x%0h data 0x%0h", addr1_reg, mem[addr1_reg]);
    end
  end

  a_clear_not_ready: assert property (@(posedge clk0) (state == ST_CLEAR) |-> !ready);
  a_ready_sticky:    assert property (@(posedge clk0) (ready && !rst0) |=> ready);
  a_reset_drops:     assert property (@(posedge clk0) rst0 |=> (!ready && dout0 == '0 && dout1 == '0));

endmodule

// File: tb/tb_gf180_sram_1rw1r_wmask.sv
// Scoreboard bench: reads push expected words into per-port queues, a monitor
// pops and compares one cycle after capture.
module tb_gf180_sram_1rw1r_wmask;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 4;
  localparam int unsigned MW = 2;

  logic clk0 = 1'b0;
  always #5 clk0 = ~clk0;

  logic          rst0, csb0, web0, csb1, ready;
  logic [MW-1:0] wmask0;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] din0, dout0, dout1;

  logic          b_rst0, b_csb0, b_web0, b_csb1, b_ready;
  logic [MW-1:0] b_wmask0;
  logic [AW-1:0] b_addr0, b_addr1;
  logic [DW-1:0] b_din0, b_dout0, b_dout1;

  gf180_sram_1rw1r_wmask #(
    .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .WMASK_WIDTH (MW),
    .CLEAR_ON_RESET (1'b1), .VERBOSE (1'b0)
  ) dut (
    .clk0 (clk0), .rst0 (rst0), .csb0 (csb0), .web0 (web0), .wmask0 (wmask0),
    .addr0 (addr0), .din0 (din0), .dout0 (dout0), .csb1 (csb1), .addr1 (addr1),
    .dout1 (dout1), .ready (ready)
  );

  gf180_sram_1rw1r_wmask #(
    .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .WMASK_WIDTH (MW),
    .CLEAR_ON_RESET (1'b0), .VERBOSE (1'b0)
  ) dut_noclr (
    .clk0 (clk0), .rst0 (b_rst0), .csb0 (b_csb0), .web0 (b_web0), .wmask0 (b_wmask0),
    .addr0 (b_addr0), .din0 (b_din0), .dout0 (b_dout0), .csb1 (b_csb1), .addr1 (b_addr1),
    .dout1 (b_dout1), .ready (b_ready)
  );

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp0[$];
  logic [DW-1:0] exp1[$];
  bit tag0 = 1'b0;
  bit tag1 = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic cycle();
    @(posedge clk0);
    #1;
  endtask

  // Present one request to both ports of the main DUT for the next posedge.
  task automatic drive(input bit c0, input bit w0, input logic [MW-1:0] m,
                       input logic [AW-1:0] a0, input logic [DW-1:0] d,
                       input bit c1, input logic [AW-1:0] a1,
                       input bit t0, input logic [DW-1:0] e0,
                       input bit t1, input logic [DW-1:0] e1);
    csb0 = c0; web0 = w0; wmask0 = m; addr0 = a0; din0 = d;
    csb1 = c1; addr1 = a1;
    tag0 = t0; tag1 = t1;
    if (t0) exp0.push_back(e0);
    if (t1) exp1.push_back(e1);
    cycle();
  endtask

  task automatic idle();
    drive(1'b1, 1'b1, '0, '0, '0, 1'b1, '0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [MW-1:0] m);
    drive(1'b0, 1'b0, m, a, d, 1'b1, '0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic rd0(input logic [AW-1:0] a, input logic [DW-1:0] e);
    drive(1'b0, 1'b1, '0, a, '0, 1'b1, '0, 1'b1, e, 1'b0, '0);
  endtask

  task automatic rd1(input logic [AW-1:0] a, input logic [DW-1:0] e);
    drive(1'b1, 1'b1, '0, '0, '0, 1'b0, a, 1'b0, '0, 1'b1, e);
  endtask

  // Monitor: a read captured at one posedge is compared shortly after the next.
  initial begin
    bit pend0 = 1'b0;
    bit pend1 = 1'b0;
    bit cap0, cap1;
    forever begin
      @(posedge clk0);
      cap0 = tag0;
      cap1 = tag1;
      #2;
      if (pend0) begin
        if (exp0.size() == 0) check("dout0 unexpected read", dout0, 32'hdead_beef);
        else check("dout0 read", dout0, exp0.pop_front());
      end
      if (pend1) begin
        if (exp1.size() == 0) check("dout1 unexpected read", dout1, 32'hdead_beef);
        else check("dout1 read", dout1, exp1.pop_front());
      end
      pend0 = cap0;
      pend1 = cap1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst0 = 1'b1; csb0 = 1'b1; web0 = 1'b1; wmask0 = '0; addr0 = '0; din0 = '0;
    csb1 = 1'b1; addr1 = '0;
    b_rst0 = 1'b1; b_csb0 = 1'b1; b_web0 = 1'b1; b_wmask0 = '0; b_addr0 = '0;
    b_din0 = '0; b_csb1 = 1'b1; b_addr1 = '0;

    // Reset clear: two reset cycles, ready rises 16 posedges later.
    cycle();
    cycle();
    check("reset ready", ready, 0);
    check("reset dout0", dout0, 0);
    check("reset dout1", dout1, 0);
    rst0 = 1'b0;
    n = 0;
    while (!ready && n < 40) begin
      cycle();
      n++;
    end
    check("ready rise cycles", n, 16);
    for (int i = 0; i < 16; i++) rd1(AW'(i), 16'h0000);

    // Masked writes.
    wr(4'd3, 16'hABCD, 2'b11);
    wr(4'd3, 16'h1234, 2'b01);
    rd0(4'd3, 16'hAB34);
    wr(4'd3, 16'h0000, 2'b00);
    rd0(4'd3, 16'hAB34);
    rd1(4'd3, 16'hAB34);

    // Collision: port 1 sees the pre-write word, then the new one.
    wr(4'd5, 16'h0F0F, 2'b11);
    drive(1'b0, 1'b0, 2'b11, 4'd5, 16'hFFFF, 1'b0, 4'd5, 1'b0, '0, 1'b1, 16'h0F0F);
    rd1(4'd5, 16'hFFFF);
    // Both ports reading in the same cycle.
    drive(1'b0, 1'b1, '0, 4'd3, '0, 1'b0, 4'd5, 1'b1, 16'hAB34, 1'b1, 16'hFFFF);

    // Hold while deselected, then reset zeroes the outputs.
    wr(4'd1, 16'h00AA, 2'b11);
    rd0(4'd1, 16'h00AA);
    idle();
    for (int i = 0; i < 5; i++) begin
      idle();
      check("dout0 hold", dout0, 16'h00AA);
    end
    rst0 = 1'b1;
    cycle();
    check("dout0 after reset", dout0, 0);
    check("dout1 after reset", dout1, 0);
    check("ready after reset", ready, 0);

    // Reset mid-clear at clr_addr = 7, then dropped writes during the restarted clear.
    rst0 = 1'b0;
    for (int k = 1; k <= 7; k++) idle();
    check("ready mid-clear", ready, 0);
    rst0 = 1'b1;
    cycle();
    rst0 = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      if (k == 10 || k == 16) wr(4'd2, 16'h5555, 2'b11);
      else idle();
      check("ready after restart", ready, (k == 16) ? 1 : 0);
    end
    rd0(4'd2, 16'h0000);
    rd1(4'd1, 16'h0000);
    rd0(4'd3, 16'h0000);
    idle();

    // No-clear configuration: ready at first posedge after reset falls.
    check("noclr ready in reset", b_ready, 0);
    b_rst0 = 1'b0;
    idle();
    check("noclr ready", b_ready, 1);
    b_csb0 = 1'b0; b_web0 = 1'b0; b_wmask0 = 2'b11; b_addr0 = 4'd9; b_din0 = 16'hBEEF;
    idle();
    b_web0 = 1'b1; b_csb1 = 1'b0; b_addr1 = 4'd9;
    idle();
    b_csb0 = 1'b1; b_csb1 = 1'b1;
    idle();
    check("noclr dout0", b_dout0, 16'hBEEF);
    check("noclr dout1", b_dout1, 16'hBEEF);

    idle();
    idle();
    check("dout0 queue drained", exp0.size(), 0);
    check("dout1 queue drained", exp1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
